// File: rtl/branch_redirect_unit.sv
// Program counter owner for the pipeline: redirects fetch on taken EX-stage branches,
// squashes wrong-path instructions with a timed flush, and keeps saturating branch statistics.
module branch_redirect_unit #(
   parameter logic [63:0] RESET_PC     = 64'h0,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             branch_ex,
   input  logic             branch_almost_final,
   input  logic [63:0]      pc_ex,
   input  logic [63:0]      imm_ex,
   input  logic             stall,
   output logic [63:0]      pc_out,
   output logic             flush,
   output logic             redirect,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] taken_count
);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // The flush counter is preloaded with one less than the flush length because
   // the redirect cycle itself is the first flushed cycle.
   localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [63:0]      r_pc;
   logic [63:0]      w_pc_nxt;
   logic             r_flush;
   logic             w_flush_nxt;
   logic             r_redirect;
   logic             w_redirect_nxt;
   logic [2:0]       r_fcnt;
   logic [2:0]       w_fcnt_nxt;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] w_branch_cnt_nxt;
   logic [CNT_W-1:0] r_taken_cnt;
   logic [CNT_W-1:0] w_taken_cnt_nxt;

   logic             w_take;
   logic [63:0]      w_target;
   logic [63:0]      w_pc_seq;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      logic [CNT_W-1:0] res;
      if (val == {CNT_W{1'b1}}) begin
         res = val;
      end else begin
         res = val + CNT_W'(1);
      end
      return res;
   endfunction

   assign w_take   = branch_ex & branch_almost_final;
   assign w_target = pc_ex + (imm_ex << 1);
   assign w_pc_seq = stall ? r_pc : (r_pc + 64'd4);

   // Next-state, next-PC, flush sequencing and statistics update.
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_flush_nxt      = r_flush;
      w_redirect_nxt   = 1'b0;
      w_fcnt_nxt       = r_fcnt;
      w_branch_cnt_nxt = r_branch_cnt;
      w_taken_cnt_nxt  = r_taken_cnt;

      case (r_state)
         ST_RUN: begin
            if (w_take) begin
               w_pc_nxt       = w_target;
               w_redirect_nxt = 1'b1;
               w_flush_nxt    = 1'b1;
               w_fcnt_nxt     = FCNT_INIT;
               w_state_nxt    = ST_FLUSH;
            end else begin
               w_pc_nxt       = w_pc_seq;
               w_flush_nxt    = 1'b0;
               w_state_nxt    = ST_RUN;
            end

            // Stall never blocks acceptance, so counting depends on branch inputs only.
            if (branch_ex) begin
               w_branch_cnt_nxt = sat_inc(r_branch_cnt);
            end else begin
               w_branch_cnt_nxt = r_branch_cnt;
            end

            if (w_take) begin
               w_taken_cnt_nxt = sat_inc(r_taken_cnt);
            end else begin
               w_taken_cnt_nxt = r_taken_cnt;
            end
         end

         ST_FLUSH: begin
            // Branch inputs here belong to wrong-path instructions and are ignored.
            w_pc_nxt = w_pc_seq;
            if (r_fcnt == 3'd0) begin
               w_flush_nxt = 1'b0;
               w_state_nxt = ST_RUN;
            end else begin
               w_flush_nxt = 1'b1;
               w_fcnt_nxt  = r_fcnt - 3'd1;
            end
         end

         default: begin
            w_state_nxt = ST_RUN;
            w_flush_nxt = 1'b0;
            w_fcnt_nxt  = 3'd0;
         end
      endcase
   end

   // State and output registers; reset drops flush immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_RUN;
         r_pc         <= RESET_PC;
         r_flush      <= 1'b0;
         r_redirect   <= 1'b0;
         r_fcnt       <= 3'd0;
         r_branch_cnt <= {CNT_W{1'b0}};
         r_taken_cnt  <= {CNT_W{1'b0}};
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_flush      <= w_flush_nxt;
         r_redirect   <= w_redirect_nxt;
         r_fcnt       <= w_fcnt_nxt;
         r_branch_cnt <= w_branch_cnt_nxt;
         r_taken_cnt  <= w_taken_cnt_nxt;
      end
   end

   assign pc_out       = r_pc;
   assign flush        = r_flush;
   assign redirect     = r_redirect;
   assign branch_count = r_branch_cnt;
   assign taken_count  = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit: stimulus pushes expected post-edge state,
// a monitor pops and compares shortly after every rising edge.
module tb_branch_redirect_unit;

   localparam logic [63:0] RST_PC = 64'h1000;
   localparam int          FC     = 2;
   localparam int          CW     = 3;
   localparam int          CMAX   = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic          branch_ex;
   logic          branch_almost_final;
   logic [63:0]   pc_ex;
   logic [63:0]   imm_ex;
   logic          stall;
   logic [63:0]   pc_out;
   logic          flush;
   logic          redirect;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] taken_count;

   typedef struct {
      logic [63:0] pc;
      logic        fl;
      logic        rd;
      int          bc;
      int          tc;
      logic [63:0] hpc;
      bit          use_h;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [63:0] m_pc;
   int          m_frem;
   int          m_bc;
   int          m_tc;

   branch_redirect_unit #(
      .RESET_PC    (RST_PC),
      .FLUSH_CYCLES(FC),
      .CNT_W       (CW)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .branch_ex          (branch_ex),
      .branch_almost_final(branch_almost_final),
      .pc_ex              (pc_ex),
      .imm_ex             (imm_ex),
      .stall              (stall),
      .pc_out             (pc_out),
      .flush              (flush),
      .redirect           (redirect),
      .branch_count       (branch_count),
      .taken_count        (taken_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc   = RST_PC;
      m_frem = 0;
      m_bc   = 0;
      m_tc   = 0;
   endtask

   // Drive one cycle of inputs and push the expected state after the next rising edge.
   task automatic step(input logic b, input logic f, input logic [63:0] pe, input logic [63:0] im,
                       input logic st, input bit use_h, input logic [63:0] hpc);
      exp_t e;
      logic rd;
      @(negedge clk);
      branch_ex           = b;
      branch_almost_final = f;
      pc_ex               = pe;
      imm_ex              = im;
      stall               = st;
      rd                  = 1'b0;
      if (m_frem == 0) begin
         if (b && m_bc < CMAX) m_bc++;
         if (b && f) begin
            if (m_tc < CMAX) m_tc++;
            m_pc   = pe + im * 64'd2;
            rd     = 1'b1;
            m_frem = FC;
         end else if (!st) begin
            m_pc = m_pc + 64'd4;
         end
      end else begin
         if (!st) m_pc = m_pc + 64'd4;
         m_frem--;
      end
      e.pc    = m_pc;
      e.fl    = (m_frem != 0);
      e.rd    = rd;
      e.bc    = m_bc;
      e.tc    = m_tc;
      e.hpc   = hpc;
      e.use_h = use_h;
      q.push_back(e);
   endtask

   task automatic idle(input logic st);
      step(1'b0, 1'b0, 64'h0, 64'h0, st, 1'b0, 64'h0);
   endtask

   // Monitor: compare the DUT against the oldest expectation just after each edge.
   always @(posedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         #1;
         e = q.pop_front();
         chk("pc_out", pc_out, e.pc);
         chk("flush", {63'd0, flush}, {63'd0, e.fl});
         chk("redirect", {63'd0, redirect}, {63'd0, e.rd});
         chk("branch_count", {61'd0, branch_count}, 64'(e.bc));
         chk("taken_count", {61'd0, taken_count}, 64'(e.tc));
         if (e.use_h) chk("pc_hand", pc_out, e.hpc);
      end
   end

   initial begin
      reset               = 1'b0;
      branch_ex           = 1'b0;
      branch_almost_final = 1'b0;
      pc_ex               = 64'h0;
      imm_ex              = 64'h0;
      stall               = 1'b0;
      model_reset();

      #12;
      chk("rst_pc", pc_out, 64'h1000);
      chk("rst_flush", {63'd0, flush}, 64'd0);
      chk("rst_redirect", {63'd0, redirect}, 64'd0);
      chk("rst_bc", {61'd0, branch_count}, 64'd0);
      chk("rst_tc", {61'd0, taken_count}, 64'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Sequential fetch
      step(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1004);
      step(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1008);
      // Taken branch, two flush cycles
      step(1'b1, 1'b1, 64'h2000, 64'h10, 1'b0, 1'b1, 64'h2020);
      step(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h2024);
      step(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h2028);
      // Not-taken branch is counted only
      step(1'b1, 1'b0, 64'h2028, 64'h40, 1'b0, 1'b1, 64'h202C);
      // Taken with stall, then stall through flush
      step(1'b1, 1'b1, 64'h3000, 64'h8, 1'b1, 1'b1, 64'h3010);
      step(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 64'h3010);
      step(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 64'h3010);
      idle(1'b0);
      // Back-to-back taken: second ignored
      step(1'b1, 1'b1, 64'h4000, 64'h20, 1'b0, 1'b1, 64'h4040);
      step(1'b1, 1'b1, 64'h5000, 64'h4, 1'b0, 1'b1, 64'h4044);
      idle(1'b0);
      // Negative immediate on first RUN cycle after flush
      step(1'b1, 1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1, 64'h0FF0);
      idle(1'b0);
      idle(1'b0);
      // Target wraps modulo 2^64
      step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 1'b0, 1'b1, 64'h10);

      // Asynchronous reset while flushing
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_pc", pc_out, 64'h1000);
      chk("midrst_flush", {63'd0, flush}, 64'd0);
      chk("midrst_bc", {61'd0, branch_count}, 64'd0);
      chk("midrst_tc", {61'd0, taken_count}, 64'd0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      step(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1004);

      // Counter saturation
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 1'b1, 64'h8000 + 64'(i) * 64'h100, 64'h0, 1'b0, 1'b0, 64'h0);
         idle(1'b0);
         idle(1'b0);
      end
      step(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
      idle(1'b0);

      repeat (3) @(posedge clk);
      #3;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
Consumes the taken/not-taken decision from branch detection in EX and owns the program counter. On a taken branch it loads the branch target into the PC and squashes wrong-path instructions by holding a flush request to the IF/ID and ID/EX registers for a fixed number of cycles. It also keeps saturating branch statistics counters for performance debug.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
FLUSH_CYCLES, 2, cycles that flush stays high after a taken branch (legal range 1..7)
CNT_W, 32, width of the statistics counters

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (reset==0 resets)
branch_ex  input  1  EX-stage instruction is a conditional branch
branch_almost_final  input  1  condition met for the EX-stage branch (beq/blt result)
pc_ex  input  64  PC of the instruction in EX
imm_ex  input  64  sign-extended branch immediate of the EX instruction
stall  input  1  hazard unit request to hold the PC
pc_out  output  64  current fetch PC
flush  output  1  squash IF/ID and ID/EX contents (registered)
redirect  output  1  one-cycle pulse: PC was loaded with a branch target this cycle
branch_count  output  CNT_W  number of accepted branches
taken_count  output  CNT_W  number of accepted taken branches

Behaviour:
- Reset (async, reset==0): pc_out=RESET_PC, flush=0, redirect=0, counters=0, state=RUN, flush counter=0. Release is synchronous to the next clk edge.
- target = pc_ex + (imm_ex << 1), 64-bit, wraps modulo 2^64. No misalignment check.
- take = branch_ex & branch_almost_final, sampled only in RUN.
- States: RUN, FLUSH.
- RUN, take=1: next pc_out=target, redirect=1 for one cycle, flush=1, fcnt=FLUSH_CYCLES-1, go to FLUSH. take has priority over stall.
- RUN, take=0, stall=1: pc_out holds, redirect=0, flush=0.
- RUN, take=0, stall=0: pc_out <= pc_out+4 (wraps), redirect=0.
- FLUSH: flush=1. branch_ex and branch_almost_final are ignored because they come from wrong-path instructions. No redirect and no counting.
  - pc_out advances by 4 unless stall=1.
  - If fcnt==0: flush<=0 and go to RUN. Otherwise fcnt decrements.
- Flush timing: flush is high for exactly FLUSH_CYCLES consecutive cycles. The first of these is the cycle in which the target PC appears on pc_out.
- Counters are updated only in RUN:
  - branch_count increments when branch_ex=1, taken or not.
  - taken_count increments when take=1.
  - Both saturate at all-ones and never wrap.
- Stall does not suppress branch acceptance or counting in RUN.
- Reset asserted mid-FLUSH: immediate return to reset values, with flush dropping asynchronously.
- Back-to-back taken branches: the second one arrives during FLUSH and is ignored.
- A branch on the first RUN cycle after FLUSH is accepted normally.

Test Plan:
- Reset with RESET_PC=64'h1000, then release with stall=0 and no branch -> pc_out 1000, 1004, 1008 on successive cycles. flush=0, counters=0.
- branch_ex=1, branch_almost_final=1, pc_ex=64'h2000, imm_ex=64'h10 -> next pc_out=64'h2020. redirect pulses one cycle. flush high for exactly 2 cycles. taken_count=1, branch_count=1.
- branch_ex=1, branch_almost_final=0 -> pc_out continues +4, flush=0, branch_count=1, taken_count=0.
- Taken branch with stall=1 in the same cycle -> redirect wins and pc_out=target. Stall held for the next 2 cycles -> pc_out holds target while flush=1.
- Taken branch at T, second taken branch presented at T+1 with a different target -> ignored: pc_out=first target+4, taken_count=1.
- pc_ex=64'hFFFF_FFFF_FFFF_FFF0 with imm_ex=64'h10 -> target wraps to 64'h10. Separately, assert reset during FLUSH -> pc_out=RESET_PC and flush=0 before the next edge.
